// File: rtl/video_stream_pkg.sv
// Shared definitions for the video stream pipeline.
//   - Pixel field offsets within an unpacked {8'h00, R, G, B} beat.
//   - Packed-stream geometry: 3 bytes per pixel, 4 pixels per 3-word group.
//   - Phase encoding for the 4-pixel packing group.
package video_stream_pkg;

    localparam int unsigned R_MSB = 23;
    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_MSB = 15;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_MSB = 7;
    localparam int unsigned B_LSB = 0;

    localparam int unsigned BYTES_PER_PIXEL  = 3;
    localparam int unsigned PIXELS_PER_GROUP = 4;
    localparam int unsigned PIX_W            = BYTES_PER_PIXEL * 8;
    localparam int unsigned PH_W             = $clog2(PIXELS_PER_GROUP);

    typedef enum logic [PH_W-1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } ph_e;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output register.
//   aclk, aresetn      : clock, asynchronous active-low reset
//   load               : capture load_tdata/tuser/tlast and assert tvalid
//   load_t*            : word and sideband to capture
//   accept             : current word is taken downstream this cycle
//   m_axis_t*          : registered master stream
// A load in the same cycle as an accept replaces the word and keeps tvalid high.
module axis_out_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              load,
    input  logic [DATA_W-1:0] load_tdata,
    input  logic              load_tuser,
    input  logic              load_tlast,
    output logic              accept,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser
);

    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tuser_q, tuser_d;
    logic              tlast_q, tlast_d;

    assign accept = tvalid_q && m_axis_tready;

    always_comb begin
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (load) begin
            tdata_d  = load_tdata;
            tuser_d  = load_tuser;
            tlast_d  = load_tlast;
            tvalid_d = 1'b1;
        end else if (accept) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: rtl/axis_rgb_frame_packer.sv
// Packs unpacked {8'h00, R, G, B} pixels into a dense 24 bpp byte stream
// (B, G, R per pixel, little-endian, 4 pixels -> 3 words) with video framing.
//   aclk, aresetn           : clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready : one pixel per beat, bits [31:24] ignored
//   m_axis_tdata/tvalid/tready : packed words, byte0 in [7:0]
//   m_axis_tuser            : start of frame (word from pixel x=1, y=0)
//   m_axis_tlast            : end of line (word from pixel x=H_ACTIVE-1)
//   frame_done              : pulse after the last word of a frame is accepted
module axis_rgb_frame_packer
    import video_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_done
);

    localparam int unsigned XW = $clog2(H_ACTIVE);
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [PIX_W-1:0] res_q, res_d;
    logic             eof_q;
    logic             frame_done_q;

    logic [7:0]  pix_r, pix_g, pix_b;
    logic        unused_alpha;
    ph_e         ph;
    logic        pix_acc;
    logic        x_last, y_last;
    logic        produce;
    logic [31:0] word;
    logic        word_sof, word_eol, word_eof;
    logic        out_accept;

    assign pix_r        = s_axis_tdata[R_MSB:R_LSB];
    assign pix_g        = s_axis_tdata[G_MSB:G_LSB];
    assign pix_b        = s_axis_tdata[B_MSB:B_LSB];
    assign unused_alpha = ^s_axis_tdata[31:24];

    // H_ACTIVE is a multiple of 4, so the group phase is just x mod 4.
    assign ph = ph_e'(x_q[PH_W-1:0]);

    // A ph=0 pixel only fills the residual, so it never needs the output slot.
    assign s_axis_tready = (ph == PH_0) || !m_axis_tvalid || m_axis_tready;
    assign pix_acc       = s_axis_tvalid && s_axis_tready;

    assign x_last   = (x_q == XW'(H_ACTIVE - 1));
    assign y_last   = (y_q == YW'(V_ACTIVE - 1));
    assign word_sof = (x_q == XW'(1)) && (y_q == '0);
    assign word_eol = x_last;
    assign word_eof = x_last && y_last;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        word    = '0;
        produce = 1'b0;
        if (pix_acc) begin
            x_d = x_last ? '0 : x_q + 1'b1;
            if (x_last) begin
                y_d = y_last ? '0 : y_q + 1'b1;
            end
            unique case (ph)
                PH_0: begin
                    res_d = {pix_r, pix_g, pix_b};
                end
                PH_1: begin
                    word    = {pix_b, res_q[23:0]};
                    res_d   = {8'h00, pix_r, pix_g};
                    produce = 1'b1;
                end
                PH_2: begin
                    word    = {pix_g, pix_b, res_q[15:0]};
                    res_d   = {16'h0000, pix_r};
                    produce = 1'b1;
                end
                PH_3: begin
                    word    = {pix_r, pix_g, pix_b, res_q[7:0]};
                    res_d   = '0;
                    produce = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_q          <= '0;
            y_q          <= '0;
            res_q        <= '0;
            eof_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            res_q        <= res_d;
            // eof rides alongside the buffered word; y may move on before it drains.
            if (produce) begin
                eof_q <= word_eof;
            end
            frame_done_q <= out_accept && eof_q;
        end
    end

    assign frame_done = frame_done_q;

    axis_out_reg #(
        .DATA_W (32)
    ) u_out (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .load          (produce),
        .load_tdata    (word),
        .load_tuser    (word_sof),
        .load_tlast    (word_eol),
        .accept        (out_accept),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

endmodule

// File: doc/axis_rgb_frame_packer.md
# axis_rgb_frame_packer

Sink-side AXI4-Stream block placed after the skin-blur filter. It accepts one unpacked pixel per beat, formatted as {8'h00, R, G, B}. It packs the pixels into a dense 24 bpp byte stream, four pixels to three 32-bit words, and adds AXI4-Stream video framing: tuser marks start of frame and tlast marks end of line. The output is ready for a VDMA S2MM write channel.

## Interface
- H_ACTIVE, 640, active pixels per line; must be a multiple of 4 and at least 4.
- V_ACTIVE, 480, active lines per frame; must be at least 1.
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  32  pixel: [23:16]=R, [15:8]=G, [7:0]=B; bits [31:24] are ignored.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- m_axis_tdata  out  32  packed byte-stream word; byte0 is [7:0].
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last word of a line.
- m_axis_tuser  out  1  first word of a frame (SOF).
- frame_done  out  1  one-cycle pulse when the last word of a frame is accepted downstream.

## Operation
- Per-pixel byte order on the output stream is B, G, R. Bytes are packed little-endian into words.
- Pixels k..k+3 of a group produce three words:
  - w0 = {B1, R0, G0, B0}
  - w1 = {G2, B2, R1, G1}
  - w2 = {R3, G3, B3, R2}
- Phase counter `ph`, 2 bits, equals the pixel index mod 4. Residual register holds 24 bits.
  - ph=0: store B0, G0, R0 in the residual; no word is produced.
  - ph=1: emit w0; keep {R1, G1} as the residual.
  - ph=2: emit w1; keep R2.
  - ph=3: emit w2; residual becomes empty.
- Position counters:
  - x counts 0..H_ACTIVE-1 and wraps to 0.
  - y increments when x wraps, counts 0..V_ACTIVE-1, and wraps to 0.
  - ph wraps together with x, because H_ACTIVE is a multiple of 4.
- Framing:
  - tuser=1 only on the word produced by pixel x=1, y=0.
  - tlast=1 only on the word produced by pixel x=H_ACTIVE-1.
  - Both flags are registered together with their word.
- Output stage is a single-entry register holding tdata, tuser and tlast.
  - m_axis_tvalid is set when a word is produced.
  - m_axis_tvalid is cleared on a downstream accept if no new word is produced in the same cycle.
- Ready: s_axis_tready = (ph==0) || !m_axis_tvalid || m_axis_tready. This is combinational; no skid buffer.
- Simultaneous output accept and new word produced: the output register loads the new word and tvalid stays 1.
- frame_done pulses in the cycle after an accepted word that has tlast=1 with y=V_ACTIVE-1 (registered).
- Upstream stall mid-group: the residual and ph are held indefinitely; no timeout and no flush.

## Timing
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, frame_done=0; ph, x, y and the residual are all 0.
- s_axis_tready is 1 immediately after reset, because ph=0.
- Latency: a word is valid on the cycle after the completing pixel (ph=1..3) is accepted.
- Throughput: one pixel per cycle while m_axis_tready=1, giving 3 words per 4 cycles.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, tdata, tuser and tlast are held stable.
- Reset mid-operation: the partial group, pending word and counters are discarded. The next accepted pixel is x=0, y=0.
- No combinational path from s_axis_tvalid to any output.

## Structure
- Shared package video_stream_pkg:
  - pixel field offsets (R_MSB/LSB, G_MSB/LSB, B_MSB/LSB);
  - BYTES_PER_PIXEL=3 and PIXELS_PER_GROUP=4;
  - ph encoding constants PH_0..PH_3.
- One sub-module is natural: axis_out_reg, a single-entry AXI-Stream output register with a load/accept interface. It is reusable by the other pipeline stages.
- The packing datapath and x/y counters stay in the top module.

## Test plan
- H=4, V=2, continuous tready. Pixels 0x00112233, 0x00445566, 0x00778899, 0x00AABBCC → words 0x66112233 (tuser=1), 0x88994455, 0xAABBCC77 (tlast=1).
- Same stimulus on line y=1 → identical words with tuser=0 and tlast on the third word; frame_done pulses once, 1 cycle after that accept.
- Upper byte set: pixel 0xFF112233 in the first group → w0 = 0x66112233; byte 31:24 is ignored.
- m_axis_tready held 0 for 10 cycles after w0 → tdata stays 0x66112233, s_axis_tready=0 at ph=1..3, no data is lost, and the sequence resumes intact.
- Random tvalid/tready at 50% over 3 frames of H=8, V=3 → 18 words per frame, tuser and tlast count and positions correct, output matches the reference model.
- aresetn asserted after 2 pixels of a group → all outputs 0; the next 4 pixels produce w0 with tuser=1.
